// File: rtl/fp_mul_int_pipe.sv
// Multi-lane FP16 x signed INT4/INT8 multiplier with an elastic valid/ready pipeline.
// Each enabled lane produces an exact FP32 product plus {NV, NAN_OUT} flags.
// A sticky status register accumulates the flags of every delivered result.
module fp_mul_int_pipe #(
    parameter int NumLanes    = 4,
    parameter int NumPipeRegs = 2,
    parameter int IntWidthMax = 8,
    parameter int NumFlags    = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NumLanes*16-1:0]          a_i,
    input  logic [NumLanes*IntWidthMax-1:0] b_i,
    input  logic                            int_fmt_i,
    input  logic [NumLanes-1:0]             lane_en_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NumLanes*32-1:0]          result_o,
    output logic [NumLanes*NumFlags-1:0]    flags_o,
    output logic [1:0]                      status_o,
    input  logic                            clr_status_i
);

    localparam int ResW = NumLanes * 32;
    localparam int FlgW = NumLanes * NumFlags;
    localparam int PayW = ResW + FlgW;

    // One lane: returns {NV, NAN_OUT, fp32_result}. The product of an 11-bit
    // significand and an 8-bit magnitude fits in 19 bits, so it is exact.
    function automatic logic [33:0] lane_mul(
        input logic [15:0] a,
        input logic [7:0]  b,
        input logic        fmt,
        input logic        en
    );
        logic [7:0]  b_s;
        logic        b_neg;
        logic [7:0]  b_mag;
        logic        sgn;
        logic [4:0]  ex;
        logic [9:0]  man;
        logic [4:0]  ex_eff;
        logic [10:0] sig;
        logic [18:0] prod;
        logic [4:0]  lead;
        logic [22:0] mant;
        logic [7:0]  e32;
        logic [31:0] res;
        logic        nv;
        logic        nan;

        // INT4 uses the low nibble of the slot, sign-extended.
        b_s    = fmt ? b : {{4{b[3]}}, b[3:0]};
        b_neg  = b_s[7];
        b_mag  = b_neg ? (~b_s + 8'd1) : b_s;
        sgn    = a[15] ^ b_neg;
        ex     = a[14:10];
        man    = a[9:0];
        // Subnormals share the exponent of the smallest normal, minus the hidden one.
        ex_eff = (ex == 5'd0) ? 5'd1 : ex;
        sig    = (ex == 5'd0) ? {1'b0, man} : {1'b1, man};
        prod   = {8'd0, sig} * {11'd0, b_mag};

        lead = 5'd0;
        for (int i = 0; i < 19; i++) begin
            if (prod[i]) begin
                lead = 5'(i);
            end else begin
                lead = lead;
            end
        end
        // Shift the leading one to bit 23; the bits below it are the mantissa.
        mant = 23'({23'd0, prod} << (5'd23 - lead));
        // FP32 exponent: ex_eff - 15 (FP16 bias) - 10 (fraction bits) + lead + 127.
        e32  = {3'd0, ex_eff} + 8'd102 + {3'd0, lead};

        nv  = 1'b0;
        nan = 1'b0;
        if (!en) begin
            res = 32'h0000_0000;
        end else if ((ex == 5'h1F) && (man != 10'd0)) begin
            // Quiet bit clear means signalling NaN.
            res = 32'h7FC0_0000;
            nan = 1'b1;
            nv  = ~man[9];
        end else if (ex == 5'h1F) begin
            if (b_mag == 8'd0) begin
                res = 32'h7FC0_0000;
                nan = 1'b1;
                nv  = 1'b1;
            end else begin
                res = {sgn, 8'hFF, 23'd0};
            end
        end else if (prod == 19'd0) begin
            res = {sgn, 31'd0};
        end else begin
            res = {sgn, e32, mant};
        end
        return {nv, nan, res};
    endfunction

    logic [ResW-1:0] comb_res_s;
    logic [FlgW-1:0] comb_flg_s;
    logic [33:0]     lm_s;

    // Evaluate every lane on the incoming operands.
    always_comb begin
        comb_res_s = '0;
        comb_flg_s = '0;
        lm_s       = '0;
        for (int k = 0; k < NumLanes; k++) begin
            lm_s = lane_mul(a_i[16*k +: 16], b_i[IntWidthMax*k +: 8], int_fmt_i, lane_en_i[k]);
            comb_res_s[32*k +: 32]             = lm_s[31:0];
            comb_flg_s[NumFlags*k +: NumFlags] = lm_s[33:32];
        end
    end

    generate
        if (NumPipeRegs == 0) begin : g_comb
            assign out_valid_o = in_valid_i;
            assign in_ready_o  = out_ready_i;
            assign result_o    = comb_res_s;
            assign flags_o     = comb_flg_s;
        end else begin : g_pipe
            logic [NumPipeRegs-1:0] vld_q;
            logic [NumPipeRegs-1:0] vld_d;
            logic [NumPipeRegs-1:0] adv_s;
            logic [NumPipeRegs-1:0] ld_s;
            logic [NumPipeRegs:0]   rdy_s;
            logic [PayW-1:0]        dat_q [NumPipeRegs];

            // Backward ready chain: a stage can take data if empty or draining.
            always_comb begin
                rdy_s              = '0;
                adv_s              = '0;
                ld_s               = '0;
                vld_d              = '0;
                rdy_s[NumPipeRegs] = out_ready_i;
                for (int s = NumPipeRegs - 1; s >= 0; s--) begin
                    rdy_s[s] = ~vld_q[s] | rdy_s[s+1];
                    adv_s[s] = vld_q[s] & rdy_s[s+1];
                end
                ld_s[0] = in_valid_i & rdy_s[0];
                for (int s = 1; s < NumPipeRegs; s++) begin
                    ld_s[s] = adv_s[s-1];
                end
                for (int s = 0; s < NumPipeRegs; s++) begin
                    vld_d[s] = ld_s[s] | (vld_q[s] & ~adv_s[s]);
                end
            end

            // Stage valid bits and payload registers; payload only moves on load.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int s = 0; s < NumPipeRegs; s++) begin
                        dat_q[s] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    if (ld_s[0]) begin
                        dat_q[0] <= {comb_flg_s, comb_res_s};
                    end
                    for (int s = 1; s < NumPipeRegs; s++) begin
                        if (ld_s[s]) begin
                            dat_q[s] <= dat_q[s-1];
                        end
                    end
                end
            end

            assign in_ready_o  = rdy_s[0];
            assign out_valid_o = vld_q[NumPipeRegs-1];
            assign result_o    = dat_q[NumPipeRegs-1][ResW-1:0];
            assign flags_o     = dat_q[NumPipeRegs-1][PayW-1:ResW];
        end
    endgenerate

    logic [1:0] flg_or_s;
    logic [1:0] hs_flg_s;
    logic [1:0] status_d;
    logic [1:0] status_q;

    // Sticky status next state; a coinciding handshake overrides the clear.
    always_comb begin
        flg_or_s = 2'b00;
        for (int k = 0; k < NumLanes; k++) begin
            flg_or_s = flg_or_s | flags_o[NumFlags*k +: 2];
        end
        if (out_valid_o && out_ready_i) begin
            hs_flg_s = flg_or_s;
        end else begin
            hs_flg_s = 2'b00;
        end
        if (clr_status_i) begin
            status_d = hs_flg_s;
        end else begin
            status_d = status_q | hs_flg_s;
        end
    end

    // Sticky status register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= 2'b00;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: tb/tb_fp_mul_int_pipe.sv
// Self-checking bench for fp_mul_int_pipe (4 lanes, 2 pipeline registers).
// Expected results come from a real-arithmetic model and a scoreboard queue.
module tb_fp_mul_int_pipe;

    localparam int NL = 4;
    localparam int NP = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [NL*16-1:0]  a_i;
    logic [NL*8-1:0]   b_i;
    logic              int_fmt_i;
    logic [NL-1:0]     lane_en_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [NL*32-1:0]  result_o;
    logic [NL*2-1:0]   flags_o;
    logic [1:0]        status_o;
    logic              clr_status_i;

    fp_mul_int_pipe #(
        .NumLanes   (NL),
        .NumPipeRegs(NP),
        .IntWidthMax(8),
        .NumFlags   (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .int_fmt_i   (int_fmt_i),
        .lane_en_i   (lane_en_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .status_o    (status_o),
        .clr_status_i(clr_status_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    // Returns {NV, NAN_OUT, fp32}.
    function automatic logic [33:0] model_lane(input logic [15:0] a, input logic [7:0] b,
                                               input logic fmt, input logic en);
        int          bv;
        int          ex;
        int          man;
        logic        sgn;
        real         mag;
        logic [63:0] db;
        int          fe;
        if (!en) return 34'd0;
        if (fmt) bv = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        else     bv = (b[3:0] >= 4'd8) ? int'(b[3:0]) - 16 : int'(b[3:0]);
        ex  = int'(a[14:10]);
        man = int'(a[9:0]);
        sgn = a[15] ^ (bv < 0);
        if (ex == 31 && man != 0) return {~a[9], 1'b1, 32'h7FC0_0000};
        if (ex == 31) begin
            if (bv == 0) return {2'b11, 32'h7FC0_0000};
            return {2'b00, sgn, 8'hFF, 23'd0};
        end
        if (ex == 0) mag = real'(man) * pow2(-24);
        else         mag = real'(1024 + man) * pow2(ex - 25);
        mag = mag * real'((bv < 0) ? -bv : bv);
        if (mag == 0.0) return {2'b00, sgn, 31'd0};
        db = $realtobits(mag);
        fe = int'(db[62:52]) - 1023 + 127;
        return {2'b00, sgn, fe[7:0], db[51:29]};
    endfunction

    typedef struct {
        logic [NL*32-1:0] res;
        logic [NL*2-1:0]  flg;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e_mon;
    exp_t             e_new;
    logic [33:0]      m_s;
    logic [1:0]       st_model = 2'b00;
    logic [1:0]       hs_flg;
    logic             stall_prev = 1'b0;
    logic [NL*32-1:0] prev_res;
    logic [NL*2-1:0]  prev_flg;
    int               acc_cnt = 0;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            st_model   = 2'b00;
            stall_prev = 1'b0;
        end else begin
            check_eq("status", 64'(status_o), 64'(st_model));
            if (stall_prev) begin
                check_eq("hold_valid", 64'(out_valid_o), 64'd1);
                check_eq("hold_res_lo", result_o[63:0], prev_res[63:0]);
                check_eq("hold_res_hi", result_o[127:64], prev_res[127:64]);
                check_eq("hold_flags", 64'(flags_o), 64'(prev_flg));
            end
            hs_flg = 2'b00;
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 64'(out_valid_o), 64'd0);
                end else if (out_ready_i) begin
                    e_mon = exp_q.pop_front();
                    for (int k = 0; k < NL; k++) begin
                        check_eq($sformatf("lane%0d_res", k), 64'(result_o[32*k +: 32]),
                                 64'(e_mon.res[32*k +: 32]));
                        hs_flg = hs_flg | e_mon.flg[2*k +: 2];
                    end
                    check_eq("flags", 64'(flags_o), 64'(e_mon.flg));
                end
            end
            if (clr_status_i) st_model = hs_flg;
            else              st_model = st_model | hs_flg;
            stall_prev = out_valid_o && !out_ready_i;
            prev_res   = result_o;
            prev_flg   = flags_o;
            if (in_valid_i && in_ready_o) begin
                for (int k = 0; k < NL; k++) begin
                    m_s = model_lane(a_i[16*k +: 16], b_i[8*k +: 8], int_fmt_i, lane_en_i[k]);
                    e_new.res[32*k +: 32] = m_s[31:0];
                    e_new.flg[2*k +: 2]   = m_s[33:32];
                end
                exp_q.push_back(e_new);
                acc_cnt++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] rand_fp16();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v[14:0] = 15'd0;
            1: v[14:10] = 5'd0;
            2: begin v[14:10] = 5'h1F; v[9:0] = 10'd0; end
            3: v[14:10] = 5'h1F;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [NL*16-1:0] rand_a();
        logic [NL*16-1:0] v;
        for (int k = 0; k < NL; k++) v[16*k +: 16] = rand_fp16();
        return v;
    endfunction

    // Present one transaction and return #1 after the edge that accepts it.
    task automatic send(input logic [NL*16-1:0] a, input logic [NL*8-1:0] b,
                        input logic fmt, input logic [NL-1:0] en);
        int guard;
        in_valid_i = 1'b1;
        a_i        = a;
        b_i        = b;
        int_fmt_i  = fmt;
        lane_en_i  = en;
        guard      = 0;
        @(negedge clk_i);
        while (!in_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) check_eq("send_timeout", 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Single transaction through an empty pipe with out_ready_i=1.
    task automatic run1(input string tag, input logic [NL*16-1:0] a, input logic [NL*8-1:0] b,
                        input logic fmt, input logic [NL-1:0] en,
                        input logic [NL*32-1:0] er, input logic [NL*2-1:0] ef);
        int cnt;
        send(a, b, fmt, en);
        cnt = 0;
        do begin
            @(negedge clk_i);
            cnt++;
        end while (!out_valid_o && cnt < 20);
        check_eq($sformatf("%s_lat", tag), 64'(cnt), 64'(NP));
        for (int k = 0; k < NL; k++) begin
            check_eq($sformatf("%s_l%0d", tag, k), 64'(result_o[32*k +: 32]), 64'(er[32*k +: 32]));
        end
        check_eq($sformatf("%s_flg", tag), 64'(flags_o), 64'(ef));
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_empty();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            @(negedge clk_i);
            cnt++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    logic acc;

    initial begin
        rst_i        = 1'b1;
        in_valid_i   = 1'b0;
        a_i          = '0;
        b_i          = '0;
        int_fmt_i    = 1'b0;
        lane_en_i    = '0;
        out_ready_i  = 1'b0;
        clr_status_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_valid", 64'(out_valid_o), 64'd0);
        check_eq("rst_res_lo", result_o[63:0], 64'd0);
        check_eq("rst_res_hi", result_o[127:64], 64'd0);
        check_eq("rst_flags", 64'(flags_o), 64'd0);
        check_eq("rst_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;

        // Directed arithmetic cases.
        run1("int8_m3", 64'h0000_0000_0000_3C00, 32'h0000_00FD, 1'b1, 4'b0001,
             {96'd0, 32'hC040_0000}, 8'd0);
        run1("int4", 64'h4000_4000_4000_4000, 32'h07F8_07F8, 1'b0, 4'b1111,
             {32'h4160_0000, 32'hC180_0000, 32'h4160_0000, 32'hC180_0000}, 8'd0);
        run1("int8", 64'h4000_4000_4000_4000, 32'h07F8_07F8, 1'b1, 4'b1111,
             {32'h4160_0000, 32'hC180_0000, 32'h4160_0000, 32'hC180_0000}, 8'd0);
        run1("special", 64'h7D00_FC00_7C00_0001, 32'h0302_0005, 1'b1, 4'b0111,
             {32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h34A0_0000}, 8'b00_00_11_00);
        @(negedge clk_i);
        check_eq("status_set", 64'(status_o), 64'd3);
        @(posedge clk_i);
        #1;
        clr_status_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_status_i = 1'b0;
        @(negedge clk_i);
        check_eq("status_clr", 64'(status_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Backpressure: 6 back-to-back with the output stalled for 5 cycles.
        out_ready_i = 1'b0;
        acc_cnt     = 0;
        fork
            begin
                for (int t = 0; t < 6; t++) send(rand_a(), $urandom, 1'($urandom), 4'($urandom));
            end
            begin
                repeat (5) @(negedge clk_i);
                check_eq("bp_accepted", 64'(acc_cnt), 64'd2);
                check_eq("bp_ready", 64'(in_ready_o), 64'd0);
                check_eq("bp_valid", 64'(out_valid_o), 64'd1);
                @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
                for (int t = 0; t < 6; t++) begin
                    @(negedge clk_i);
                    check_eq($sformatf("bp_nogap%0d", t), 64'(out_valid_o), 64'd1);
                end
            end
        join
        wait_empty();

        // Reset with two transactions in flight.
        run1("pre_rst", 64'h0000_0000_0000_7C00, 32'h0000_0000, 1'b1, 4'b0001,
             {96'd0, 32'h7FC0_0000}, 8'b00_00_00_11);
        out_ready_i = 1'b0;
        send(rand_a(), $urandom, 1'b1, 4'b1111);
        send(rand_a(), $urandom, 1'b1, 4'b1111);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("mid_rst_valid", 64'(out_valid_o), 64'd0);
        check_eq("mid_rst_status", 64'(status_o), 64'd0);
        check_eq("mid_rst_ready", 64'(in_ready_o), 64'd1);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_i);
            check_eq("rst_flush", 64'(out_valid_o), 64'd0);
        end
        @(posedge clk_i);
        #1;
        run1("post_rst", 64'h0000_0000_0000_4000, 32'h0000_0007, 1'b1, 4'b0001,
             {96'd0, 32'h4160_0000}, 8'd0);

        // Sticky status: clear coinciding with a qNaN handshake keeps the new flags.
        run1("snan", 64'h0000_0000_0000_7D00, 32'h0000_0001, 1'b1, 4'b0001,
             {96'd0, 32'h7FC0_0000}, 8'b00_00_00_11);
        send(64'h0000_0000_0000_7E00, 32'h0000_0001, 1'b1, 4'b0001);
        @(posedge clk_i);
        #1;
        clr_status_i = 1'b1;
        @(negedge clk_i);
        check_eq("coll_valid", 64'(out_valid_o), 64'd1);
        @(posedge clk_i);
        #1;
        clr_status_i = 1'b0;
        @(negedge clk_i);
        check_eq("coll_status", 64'(status_o), 64'd1);
        @(posedge clk_i);
        #1;
        clr_status_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_status_i = 1'b0;
        @(negedge clk_i);
        check_eq("clr_only", 64'(status_o), 64'd0);
        @(posedge clk_i);
        #1;

        // Randomized traffic with random backpressure and clears.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            acc = in_valid_i && in_ready_o;
            @(posedge clk_i);
            #1;
            if (!in_valid_i || acc) begin
                in_valid_i = ($urandom_range(0, 9) < 7);
                a_i        = rand_a();
                b_i        = $urandom;
                int_fmt_i  = 1'($urandom);
                lane_en_i  = 4'($urandom);
            end
            out_ready_i  = ($urandom_range(0, 9) < 7);
            clr_status_i = ($urandom_range(0, 19) == 0);
        end
        in_valid_i   = 1'b0;
        clr_status_i = 1'b0;
        out_ready_i  = 1'b1;
        wait_empty();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
